fu_program_loader: RTL and testbench

Upstream feeder for the functional unit (FU). It accepts 48-bit program lines one at a time over a valid/ready handshake and packs them into a shadow buffer of 16 slots. When a program is complete, it publishes the whole image on the FU's 768-bit `PROGRAM_LINES` bus and 5-bit `PROGRAM_LINES_COUNT` bus. It then pulses the FU reset so the FU restarts on the new program. Double-buffering keeps the FU-facing buses stable while the next program is loading.

---
 rtl/fu_program_loader.sv | 122 ++++++++++++
 tb/tb_fu_program_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fu_program_loader.sv
// Program loader for the functional unit: packs 48-bit lines into a shadow buffer,
// publishes the finished image on a double-buffered bus and pulses FU_RESET.
module fu_program_loader #(
    parameter int unsigned RESET_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          LINE_VALID,
    input  logic [47:0]   LINE_DATA,
    input  logic          LINE_LAST,
    output logic          LINE_READY,
    output logic [767:0]  PROGRAM_LINES,
    output logic [4:0]    PROGRAM_LINES_COUNT,
    output logic          FU_RESET,
    output logic          BUSY
);

    localparam logic [3:0] LAUNCH_INIT = 4'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_LAUNCH = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     wp_q, wp_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [767:0]   shadow_q, shadow_d;
    logic [767:0]   prog_q, prog_d;
    logic [4:0]     count_q, count_d;
    logic           ready_q, ready_d;
    logic           fu_reset_q, fu_reset_d;
    logic           busy_q, busy_d;
    logic           accept_s;
    logic           complete_s;
    logic [767:0]   line_img_s;

    // Next-state, buffer and published-image logic
    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        prog_d     = prog_q;
        count_d    = count_q;
        accept_s   = LINE_VALID && ready_q;
        complete_s = accept_s && (LINE_LAST || (wp_q == 4'd15));
        line_img_s = shadow_q;
        line_img_s[10'(wp_q) * 10'd48 +: 48] = LINE_DATA;

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (complete_s) begin
                    // The shadow keeps its contents until the launch ends, then is cleared
                    prog_d  = line_img_s;
                    count_d = 5'(wp_q) + 5'd1;
                    cnt_d   = LAUNCH_INIT;
                    state_d = ST_LAUNCH;
                end else if (accept_s) begin
                    shadow_d = line_img_s;
                    wp_d     = wp_q + 4'd1;
                    state_d  = ST_FILL;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LAUNCH: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_IDLE;
                    shadow_d = 768'd0;
                    wp_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                shadow_d = 768'd0;
                wp_d     = 4'd0;
                cnt_d    = 4'd0;
            end
        endcase

        // Handshake and status outputs are registered copies of the next state
        ready_d    = (state_d != ST_LAUNCH);
        fu_reset_d = (state_d == ST_LAUNCH);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            wp_q       <= 4'd0;
            cnt_q      <= 4'd0;
            shadow_q   <= 768'd0;
            prog_q     <= 768'd0;
            count_q    <= 5'd0;
            ready_q    <= 1'b1;
            fu_reset_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            prog_q     <= prog_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            fu_reset_q <= fu_reset_d;
            busy_q     <= busy_d;
        end
    end

    assign LINE_READY          = ready_q;
    assign PROGRAM_LINES       = prog_q;
    assign PROGRAM_LINES_COUNT = count_q;
    assign FU_RESET            = fu_reset_q;
    assign BUSY                = busy_q;

endmodule

// File: tb/tb_fu_program_loader.sv
// Bench for fu_program_loader: two instances (RESET_CYCLES 1 and 3) driven by directed and
// random steps, compared every cycle against a queue-based model of the loader.
module tb_fu_program_loader;

    logic         clk = 1'b0;
    logic         sel;
    logic         vld, last, rst;
    logic [47:0]  data;

    logic         rdy1, fr1, busy1, rdy3, fr3, busy3;
    logic [767:0] prog1, prog3;
    logic [4:0]   cnt1, cnt3;

    logic [47:0]  mq[$];
    logic [767:0] m_prog;
    int           m_count, m_left, m_rc;
    int           checks, errors;

    always #5 clk = ~clk;

    fu_program_loader u_rc1 (
        .CLK(clk), .RESET(rst & ~sel), .LINE_VALID(vld & ~sel), .LINE_DATA(data),
        .LINE_LAST(last), .LINE_READY(rdy1), .PROGRAM_LINES(prog1),
        .PROGRAM_LINES_COUNT(cnt1), .FU_RESET(fr1), .BUSY(busy1)
    );

    fu_program_loader #(.RESET_CYCLES(3)) u_rc3 (
        .CLK(clk), .RESET(rst & sel), .LINE_VALID(vld & sel), .LINE_DATA(data),
        .LINE_LAST(last), .LINE_READY(rdy3), .PROGRAM_LINES(prog3),
        .PROGRAM_LINES_COUNT(cnt3), .FU_RESET(fr3), .BUSY(busy3)
    );

    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare all outputs after it
    task automatic cyc(input logic v, input logic [47:0] d, input logic l, input logic r);
        bit m_ready;
        vld = v; data = d; last = l; rst = r;
        @(posedge clk);
        m_ready = (m_left == 0);
        if (r) begin
            mq.delete(); m_prog = '0; m_count = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (v && m_ready) begin
            mq.push_back(d);
            if (l || mq.size() == 16) begin
                m_prog = '0;
                foreach (mq[i]) m_prog[i*48 +: 48] = mq[i];
                m_count = mq.size();
                mq.delete();
                m_left = m_rc;
            end
        end
        #1;
        chk("line_ready", 768'(sel ? rdy3 : rdy1), 768'(m_left == 0));
        chk("fu_reset", 768'(sel ? fr3 : fr1), 768'(m_left > 0));
        chk("busy", 768'(sel ? busy3 : busy1), 768'((m_left > 0) || (mq.size() > 0)));
        chk("count", 768'(sel ? cnt3 : cnt1), 768'(m_count));
        chk("program_lines", sel ? prog3 : prog1, m_prog);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 48'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [767:0] exp_img;
        logic [63:0]  rnd;
        checks = 0; errors = 0;
        vld = 1'b0; data = 48'h0; last = 1'b0; rst = 1'b1;

        // Reset, RESET_CYCLES = 1 instance
        sel = 1'b0; m_rc = 1;
        cyc(1'b0, 48'h0, 1'b0, 1'b1);
        cyc(1'b0, 48'h0, 1'b0, 1'b1);
        idle(1);
        chk("reset_ready", 768'(rdy1), 768'(1));

        // 3-line program
        cyc(1'b1, 48'h1, 1'b0, 1'b0);
        cyc(1'b1, 48'h2, 1'b0, 1'b0);
        cyc(1'b1, 48'h3, 1'b1, 1'b0);
        exp_img = '0;
        exp_img[143:0] = {48'h3, 48'h2, 48'h1};
        chk("three_img", prog1, exp_img);
        chk("three_count", 768'(cnt1), 768'(3));
        chk("three_fu_reset", 768'(fr1), 768'(1));
        idle(1);
        chk("three_reset_drop", 768'(fr1), 768'(0));

        // 16 lines without LAST, then a 17th line held during launch
        for (int i = 0; i < 16; i++) cyc(1'b1, 48'h100 + 48'(i), 1'b0, 1'b0);
        chk("sixteen_count", 768'(cnt1), 768'(16));
        chk("sixteen_not_ready", 768'(rdy1), 768'(0));
        cyc(1'b1, 48'hABC, 1'b1, 1'b0);
        cyc(1'b1, 48'hABC, 1'b1, 1'b0);
        chk("held_line_count", 768'(cnt1), 768'(1));
        idle(1);

        // Double buffer hold
        cyc(1'b1, 48'h21, 1'b0, 1'b0);
        cyc(1'b1, 48'h22, 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 48'h300 + 48'(i), 1'b0, 1'b0);
        chk("hold_count", 768'(cnt1), 768'(2));
        cyc(1'b1, 48'h305, 1'b1, 1'b0);
        chk("second_count", 768'(cnt1), 768'(6));
        idle(1);

        // Reset mid-fill, then a 1-line program
        for (int i = 0; i < 4; i++) cyc(1'b1, 48'h400 + 48'(i), 1'b0, 1'b0);
        cyc(1'b0, 48'h0, 1'b0, 1'b1);
        cyc(1'b1, 48'h55, 1'b1, 1'b0);
        exp_img = '0;
        exp_img[47:0] = 48'h55;
        chk("midfill_img", prog1, exp_img);
        chk("midfill_count", 768'(cnt1), 768'(1));
        idle(1);

        // Handshake gaps with RESET_CYCLES = 3
        sel = 1'b1; m_rc = 3;
        cyc(1'b0, 48'h0, 1'b0, 1'b1);
        cyc(1'b0, 48'h0, 1'b0, 1'b1);
        cyc(1'b1, 48'hA1, 1'b0, 1'b0);
        cyc(1'b0, 48'hFF, 1'b1, 1'b0);
        cyc(1'b1, 48'hA2, 1'b0, 1'b0);
        cyc(1'b0, 48'hFF, 1'b1, 1'b0);
        cyc(1'b1, 48'hA3, 1'b1, 1'b0);
        chk("gap_count", 768'(cnt3), 768'(3));
        idle(2);
        chk("gap_fu_reset_3rd", 768'(fr3), 768'(1));
        idle(1);
        chk("gap_fu_reset_fall", 768'(fr3), 768'(0));
        idle(1);

        // Random traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            m_rc = (s == 1) ? 3 : 1;
            cyc(1'b0, 48'h0, 1'b0, 1'b1);
            for (int i = 0; i < 400; i++) begin
                rnd = {$urandom(), $urandom()};
                cyc(($urandom % 4) != 0, rnd[47:0], ($urandom % 6) == 0, ($urandom % 60) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
